query_patch_wb_loader: RTL and testbench

- Wishbone slave controller that owns port 0 (csb0/web0/addr0/wpatch0/rpatch0) of the query patch memory.
- Host-side DATA writes of one DATA_WIDTH element each are packed into PATCH_SIZE-element patches, and each completed patch is written to memory at an auto-incrementing patch address.
- Patches can be read back element by element.
- Arbitrates port 0 between this loader (wb_mode=1) and the core datapath (wb_mode=0).

---
 rtl/query_patch_wb_loader.sv | 159 +++++++++++++++
 tb/tb_query_patch_wb_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/query_patch_wb_loader.sv
// Wishbone slave that packs host-written elements into patches and owns port 0
// of the query patch memory while wb_mode is set; otherwise port 0 follows the core.
module query_patch_wb_loader #(
  parameter int          DATA_WIDTH = 11,
  parameter int          PATCH_SIZE = 5,
  parameter int          ADDR_WIDTH = 9,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             wbs_stb_i,
  input  logic                             wbs_cyc_i,
  input  logic                             wbs_we_i,
  input  logic [3:0]                       wbs_sel_i,
  input  logic [31:0]                      wbs_dat_i,
  input  logic [31:0]                      wbs_adr_i,
  output logic                             wbs_ack_o,
  output logic [31:0]                      wbs_dat_o,
  input  logic                             core_csb0,
  input  logic                             core_web0,
  input  logic [ADDR_WIDTH-1:0]            core_addr0,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0] core_wpatch0,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] core_rpatch0,
  output logic                             core_busy,
  output logic                             mem_csb0,
  output logic                             mem_web0,
  output logic [ADDR_WIDTH-1:0]            mem_addr0,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] mem_wpatch0,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0] mem_rpatch0
);
  localparam int PW = DATA_WIDTH * PATCH_SIZE;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_MEM  = 3'd1;
  localparam logic [2:0] S_RD_MEM  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] LAST      = 3'(PATCH_SIZE - 1);

  logic [2:0]            state;
  logic                  wb_mode, err;
  logic [ADDR_WIDTH-1:0] patch_addr;
  logic [2:0]            elem_cnt, rd_idx;
  logic [PW-1:0]         asm_buf, wr_patch;
  logic                  fsm_csb, fsm_web;
  logic [ADDR_WIDTH-1:0] fsm_addr;
  logic [PW-1:0]         fsm_wpatch;

  logic [7:0]            off;
  logic                  hit, mapped, req;
  logic [DATA_WIDTH-1:0] elem, rd_elem;
  logic [31:0]           status, paddr_rd;
  logic                  unused_bits;

  assign off      = wbs_adr_i[7:0];
  assign hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign mapped   = (off == 8'h00) || (off == 8'h04) || (off == 8'h08) ||
                    (off == 8'h0C) || (off == 8'h10);
  assign req      = wbs_stb_i && wbs_cyc_i && hit && mapped && !wbs_ack_o;
  assign elem     = wbs_dat_i[DATA_WIDTH-1:0];
  assign rd_elem  = mem_rpatch0[rd_idx*DATA_WIDTH +: DATA_WIDTH];
  assign status   = {21'd0, rd_idx, 1'b0, elem_cnt, 2'b00, err, wb_mode};
  assign paddr_rd = {{(32-ADDR_WIDTH){1'b0}}, patch_addr};
  assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:DATA_WIDTH]};

  // Buffer with the incoming element merged in; used both to keep a partial
  // patch and as the full patch on the final element.
  always_comb begin
    wr_patch = asm_buf;
    wr_patch[elem_cnt*DATA_WIDTH +: DATA_WIDTH] = elem;
  end

  assign core_busy    = wb_mode;
  assign core_rpatch0 = mem_rpatch0;
  assign mem_csb0     = wb_mode ? fsm_csb    : core_csb0;
  assign mem_web0     = wb_mode ? fsm_web    : core_web0;
  assign mem_addr0    = wb_mode ? fsm_addr   : core_addr0;
  assign mem_wpatch0  = wb_mode ? fsm_wpatch : core_wpatch0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;  wbs_ack_o <= 1'b0;  wbs_dat_o <= '0;
      wb_mode <= 1'b0;  err <= 1'b0;  patch_addr <= '0;
      elem_cnt <= '0;   rd_idx <= '0; asm_buf <= '0;
      fsm_csb <= 1'b1;  fsm_web <= 1'b1; fsm_addr <= '0; fsm_wpatch <= '0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          state <= S_ACK; wbs_ack_o <= 1'b1; wbs_dat_o <= '0;
          case (off)
            8'h00: begin
              if (wbs_we_i) begin
                wb_mode <= wbs_dat_i[0];
                if (wbs_dat_i[1]) err <= 1'b0;
                if (!wbs_dat_i[0]) begin
                  elem_cnt <= '0; rd_idx <= '0; asm_buf <= '0;
                end
              end else begin
                wbs_dat_o <= {31'd0, wb_mode};
              end
            end
            8'h04: if (!wbs_we_i) wbs_dat_o <= status;
            8'h08: begin
              if (wbs_we_i) begin
                patch_addr <= wbs_dat_i[ADDR_WIDTH-1:0];
                elem_cnt <= '0; rd_idx <= '0; asm_buf <= '0;
              end else begin
                wbs_dat_o <= paddr_rd;
              end
            end
            8'h0C: if (wbs_we_i) begin
              if (!wb_mode) begin
                err <= 1'b1;
              end else if (elem_cnt == LAST) begin
                state <= S_WR_MEM; wbs_ack_o <= 1'b0;
                fsm_csb <= 1'b0; fsm_web <= 1'b0;
                fsm_addr <= patch_addr; fsm_wpatch <= wr_patch;
              end else begin
                asm_buf <= wr_patch; elem_cnt <= elem_cnt + 3'd1;
              end
            end
            8'h10: if (!wbs_we_i) begin
              if (!wb_mode) begin
                err <= 1'b1;
              end else begin
                state <= S_RD_MEM; wbs_ack_o <= 1'b0;
                fsm_csb <= 1'b0; fsm_web <= 1'b1; fsm_addr <= patch_addr;
              end
            end
            default: ;
          endcase
        end
        S_WR_MEM: begin
          fsm_csb <= 1'b1; fsm_web <= 1'b1;
          patch_addr <= patch_addr + 1'b1;
          elem_cnt <= '0; asm_buf <= '0;
          state <= S_ACK; wbs_ack_o <= 1'b1;
        end
        S_RD_MEM: begin
          fsm_csb <= 1'b1; fsm_web <= 1'b1;
          state <= S_RD_WAIT;
        end
        // Memory output is valid here, one cycle after the read select.
        S_RD_WAIT: begin
          wbs_dat_o <= {{(32-DATA_WIDTH){1'b0}}, rd_elem};
          if (rd_idx == LAST) begin
            rd_idx <= '0; patch_addr <= patch_addr + 1'b1;
          end else begin
            rd_idx <= rd_idx + 3'd1;
          end
          state <= S_ACK; wbs_ack_o <= 1'b1;
        end
        S_ACK: begin
          wbs_ack_o <= 1'b0; wbs_dat_o <= '0; state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_query_patch_wb_loader.sv
// Directed bench for query_patch_wb_loader with a 1-cycle-latency patch memory model.
module tb_query_patch_wb_loader;
  localparam int DW = 11, PS = 5, AW = 9, PW = DW * PS;
  localparam logic [31:0] B = 32'h3000_0000;

  logic          clk = 1'b0, rst = 1'b1;
  logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'hF;
  logic [31:0]   wdat = '0, adr = '0;
  logic          ack;
  logic [31:0]   rdat_o;
  logic          core_csb0 = 1'b1, core_web0 = 1'b1;
  logic [AW-1:0] core_addr0 = '0;
  logic [PW-1:0] core_wpatch0 = '0, core_rpatch0;
  logic          core_busy, mem_csb0, mem_web0;
  logic [AW-1:0] mem_addr0;
  logic [PW-1:0] mem_wpatch0, mem_rpatch0;

  logic [PW-1:0] mem [0:(1<<AW)-1];
  int            checks = 0, errors = 0;
  logic          wr_seen;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_patch;
  int            lat;
  logic [31:0]   rd;

  always #5 clk = ~clk;

  query_patch_wb_loader dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
    .core_csb0(core_csb0), .core_web0(core_web0), .core_addr0(core_addr0),
    .core_wpatch0(core_wpatch0), .core_rpatch0(core_rpatch0), .core_busy(core_busy),
    .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0),
    .mem_wpatch0(mem_wpatch0), .mem_rpatch0(mem_rpatch0)
  );

  initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
  always @(posedge clk) begin
    if (!mem_csb0 && !mem_web0) mem[mem_addr0] <= mem_wpatch0;
    if (!mem_csb0 &&  mem_web0) mem_rpatch0 <= mem[mem_addr0];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus transfer; lat = cycles from acceptance to ack (0 = no ack within bound).
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int l, output logic [31:0] r);
    l = 0; r = '0; wr_seen = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (!mem_csb0 && !mem_web0) begin
        wr_seen = 1'b1; wr_addr = mem_addr0; wr_patch = mem_wpatch0;
      end
      if (ack) begin l = i; r = rdat_o; break; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_dat", rdat_o, 0);
    chk("rst_busy", core_busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: STATUS after reset, and core passthrough
    xfer(0, B+8'h04, 0, lat, rd);
    chk("status_lat", lat, 1);
    chk("status_rst", rd, 0);
    core_csb0 = 0; core_web0 = 0; core_addr0 = 3; core_wpatch0 = 1;
    #1;
    chk("mux_csb", mem_csb0, 0);
    chk("mux_web", mem_web0, 0);
    chk("mux_addr", mem_addr0, 3);
    chk("mux_wpatch", mem_wpatch0, 1);
    core_csb0 = 1; core_web0 = 1; core_addr0 = 0; core_wpatch0 = 0;
    @(posedge clk); #1;

    // 2: pack one patch at address 45
    xfer(1, B+8'h00, 1, lat, rd);
    chk("ctrl_lat", lat, 1);
    xfer(1, B+8'h08, 45, lat, rd);
    for (int k = 0; k < 4; k++) begin
      xfer(1, B+8'h0C, 2 + k, lat, rd);
      chk("wdata_lat", lat, 1);
      chk("wdata_nowr", wr_seen, 0);
    end
    xfer(1, B+8'h0C, 6, lat, rd);
    chk("wfinal_lat", lat, 2);
    chk("wfinal_seen", wr_seen, 1);
    chk("wfinal_addr", wr_addr, 45);
    chk("wfinal_patch", wr_patch, {11'd6, 11'd5, 11'd4, 11'd3, 11'd2});
    xfer(0, B+8'h04, 0, lat, rd);
    chk("status_after_wr", rd, 32'h1);
    xfer(0, B+8'h08, 0, lat, rd);
    chk("paddr_after_wr", rd, 46);

    // 3: read the patch back
    xfer(1, B+8'h08, 45, lat, rd);
    for (int k = 0; k < 5; k++) begin
      xfer(0, B+8'h10, 0, lat, rd);
      chk("rdata_lat", lat, 3);
      chk("rdata_val", rd, 2 + k);
    end
    xfer(0, B+8'h08, 0, lat, rd);
    chk("paddr_after_rd", rd, 46);

    // 4: address wrap; upper data bits ignored on first element
    xfer(1, B+8'h08, 511, lat, rd);
    xfer(1, B+8'h0C, 32'hFFFF_F80A, lat, rd);
    for (int k = 1; k < 5; k++) xfer(1, B+8'h0C, 10 + k, lat, rd);
    chk("wrap_addr", wr_addr, 511);
    chk("wrap_patch", wr_patch, {11'd14, 11'd13, 11'd12, 11'd11, 11'd10});
    xfer(0, B+8'h08, 0, lat, rd);
    chk("paddr_wrap", rd, 0);

    // unmapped offset and non-hit address: no ack
    xfer(1, B+8'h14, 0, lat, rd);
    chk("unmapped_noack", lat, 0);
    xfer(0, B+32'h100, 0, lat, rd);
    chk("nohit_noack", lat, 0);

    // 5: WDATA while core owns the port
    xfer(1, B+8'h00, 0, lat, rd);
    xfer(1, B+8'h0C, 7, lat, rd);
    chk("err_lat", lat, 1);
    chk("err_nowr", wr_seen, 0);
    xfer(0, B+8'h10, 0, lat, rd);
    chk("err_rd_lat", lat, 1);
    chk("err_rd_dat", rd, 0);
    xfer(0, B+8'h04, 0, lat, rd);
    chk("status_err", rd, 32'h2);
    xfer(1, B+8'h00, 2, lat, rd);
    xfer(0, B+8'h04, 0, lat, rd);
    chk("status_errclr", rd, 0);

    // 6: partial patch discarded by leaving wb_mode
    xfer(1, B+8'h00, 1, lat, rd);
    for (int k = 0; k < 3; k++) xfer(1, B+8'h0C, 20 + k, lat, rd);
    xfer(0, B+8'h04, 0, lat, rd);
    chk("status_partial", rd, 32'h31);
    xfer(1, B+8'h00, 0, lat, rd);
    chk("discard_nowr", wr_seen, 0);
    xfer(0, B+8'h04, 0, lat, rd);
    chk("status_discard", rd, 0);

    // reset while in RD_WAIT
    xfer(1, B+8'h00, 1, lat, rd);
    stb = 1; cyc = 1; we = 0; adr = B+8'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; stb = 0; cyc = 0;
    @(posedge clk); #1;
    chk("midrst_ack", ack, 0);
    chk("midrst_dat", rdat_o, 0);
    chk("midrst_busy", core_busy, 0);
    chk("midrst_csb", mem_csb0, 1);
    rst = 0;
    @(posedge clk); #1;
    xfer(0, B+8'h04, 0, lat, rd);
    chk("midrst_status", rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
